// File: rtl/uart_bus_bridge_if.sv
// Signal bundle between the UART byte streams, the bridge and the peripheral bus.
// Handshake rule for rx and tx: a byte moves on a rising edge where valid and
// ready are both 1; valid and data stay stable until that edge.
interface uart_bus_bridge_if;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        write_valid;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        read_valid;
    logic [31:0] read_address;
    logic [31:0] read_data;

    // Bridge side: consumes rx bytes, produces tx bytes, initiates bus accesses.
    modport master (
        input  rx_data, rx_data_valid, tx_data_ready, read_data,
        output rx_data_ready, tx_data, tx_data_valid,
        output write_valid, write_address, write_data, read_valid, read_address
    );

    // Environment side: UART receiver/transmitter and bus responder.
    modport slave (
        output rx_data, rx_data_valid, tx_data_ready, read_data,
        input  rx_data_ready, tx_data, tx_data_valid,
        input  write_valid, write_address, write_data, read_valid, read_address
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// UART command bridge: decodes 'W'/'R' frames from the receive byte stream
// into 32-bit bus writes/reads and returns 'K', read data or '?' to the host.
module uart_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    uart_bus_bridge_if.master      bus,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_DATA      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ      = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_RESP      = 3'd6
    } state_t;

    localparam logic [7:0]  CMD_WRITE = 8'h57;
    localparam logic [7:0]  CMD_READ  = 8'h52;
    localparam logic [7:0]  RSP_ACK   = 8'h4B;
    localparam logic [7:0]  RSP_ERR   = 8'h3F;
    // Gap value at which an open frame is abandoned (unused when disabled).
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_sh_q, addr_sh_d;
    logic [23:0] wdata_sh_q, wdata_sh_d;
    logic [31:0] write_address_q, write_address_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] read_address_q, read_address_d;
    logic [31:0] resp_q, resp_d;
    logic [2:0]  resp_cnt_q, resp_cnt_d;
    logic [31:0] gap_q, gap_d;

    logic        rx_ready;
    logic        tx_valid;
    logic        wr_strobe;
    logic        rd_strobe;
    logic        rx_fire;
    logic        timeout_hit;

    assign rx_fire     = rx_ready && bus.rx_data_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (gap_q == TMO_LAST);

    // Next-state, datapath and handshake outputs for the frame FSM.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_write_d      = is_write_q;
        addr_sh_d       = addr_sh_q;
        wdata_sh_d      = wdata_sh_q;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        read_address_d  = read_address_q;
        resp_d          = resp_q;
        resp_cnt_d      = resp_cnt_q;
        gap_d           = 32'd0;
        rx_ready        = 1'b0;
        tx_valid        = 1'b0;
        wr_strobe       = 1'b0;
        rd_strobe       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rx_ready = 1'b1;
                cnt_d    = 2'd0;
                if (bus.rx_data_valid) begin
                    if (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ) begin
                        is_write_d = (bus.rx_data == CMD_WRITE);
                        state_d    = ST_ADDR;
                    end else begin
                        resp_d     = {RSP_ERR, 24'd0};
                        resp_cnt_d = 3'd1;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    addr_sh_d = {addr_sh_q[23:0], bus.rx_data};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = ST_DATA;
                        end else begin
                            read_address_d = {addr_sh_q[23:0], bus.rx_data};
                            state_d        = ST_READ;
                        end
                    end
                end else if (timeout_hit) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end

            ST_DATA: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    wdata_sh_d = {wdata_sh_q[15:0], bus.rx_data};
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Publish address and data together so the bus sees a
                        // coherent pair while the strobe is high.
                        write_data_d    = {wdata_sh_q, bus.rx_data};
                        write_address_d = addr_sh_q;
                        state_d         = ST_WRITE;
                    end
                end else if (timeout_hit) begin
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end

            ST_WRITE: begin
                wr_strobe  = 1'b1;
                resp_d     = {RSP_ACK, 24'd0};
                resp_cnt_d = 3'd1;
                state_d    = ST_RESP;
            end

            ST_READ: begin
                rd_strobe = 1'b1;
                state_d   = ST_READ_WAIT;
            end

            ST_READ_WAIT: begin
                // Responder registered read_data on the edge that saw read_valid.
                resp_d     = bus.read_data;
                resp_cnt_d = 3'd4;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                tx_valid = 1'b1;
                if (bus.tx_data_ready) begin
                    resp_d     = {resp_q[23:0], 8'd0};
                    resp_cnt_d = resp_cnt_q - 3'd1;
                    if (resp_cnt_q == 3'd1) begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                cnt_d   = 2'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 2'd0;
            is_write_q      <= 1'b0;
            addr_sh_q       <= 32'd0;
            wdata_sh_q      <= 24'd0;
            write_address_q <= 32'd0;
            write_data_q    <= 32'd0;
            read_address_q  <= 32'd0;
            resp_q          <= 32'd0;
            resp_cnt_q      <= 3'd0;
            gap_q           <= 32'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_write_q      <= is_write_d;
            addr_sh_q       <= addr_sh_d;
            wdata_sh_q      <= wdata_sh_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            read_address_q  <= read_address_d;
            resp_q          <= resp_d;
            resp_cnt_q      <= resp_cnt_d;
            gap_q           <= gap_d;
        end
    end

    assign bus.rx_data_ready = rx_ready;
    assign bus.tx_data_valid = tx_valid;
    assign bus.tx_data       = resp_q[31:24];
    assign bus.write_valid   = wr_strobe;
    assign bus.write_address = write_address_q;
    assign bus.write_data    = write_data_q;
    assign bus.read_valid    = rd_strobe;
    assign bus.read_address  = read_address_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: drivers push expected tx bytes and bus
// events into queues, an independent monitor pops and compares them.
module tb_uart_bus_bridge;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_RESP = 3'd6;

    logic        clk_in;
    logic        rst_n;
    logic [2:0]  state_dbg;
    logic [31:0] rd_resp;

    uart_bus_bridge_if bus ();

    uart_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_tx_q[$];
    logic [64:0] exp_bus_q[$];   // {is_write, address, data}

    // Clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Hard stop in case something wedges beyond every per-wait bound.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk_in);
        #1;
    endtask

    // Offer one byte; returns at posedge+1 of the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk_in);
            acc = bus.rx_data_ready;
            sync();
            n++;
        end
        bus.rx_data_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", 96'(acc), 96'd1);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d, input bit expect_it);
        logic [31:0] av;
        logic [31:0] dv;
        av = a;
        dv = d;
        if (expect_it) begin
            exp_bus_q.push_back({1'b1, a, d});
            exp_tx_q.push_back(8'h4B);
        end
        send_byte(8'h57);
        for (int i = 3; i >= 0; i--) send_byte(av[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(dv[i*8 +: 8]);
    endtask

    task automatic send_read(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] av;
        logic [31:0] dv;
        av = a;
        dv = d;
        rd_resp = d;
        exp_bus_q.push_back({1'b0, a, 32'd0});
        for (int i = 3; i >= 0; i--) exp_tx_q.push_back(dv[i*8 +: 8]);
        send_byte(8'h52);
        for (int i = 3; i >= 0; i--) send_byte(av[i*8 +: 8]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_tx_q.size() != 0 || exp_bus_q.size() != 0) && n < 300) begin
            sync();
            n++;
        end
        check("drain_tx_q", 96'(exp_tx_q.size()), 96'd0);
        check("drain_bus_q", 96'(exp_bus_q.size()), 96'd0);
        sync();
    endtask

    // Bus responder: data appears after the edge that samples read_valid and
    // is replaced by junk after the following edge.
    initial begin
        bus.read_data = 32'd0;
        forever begin
            @(negedge clk_in);
            if (bus.read_valid) begin
                @(posedge clk_in);
                #1 bus.read_data = rd_resp;
                @(posedge clk_in);
                #1 bus.read_data = 32'hBAAD_F00D;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic       stall;
        logic [7:0] stall_data;
        stall      = 1'b0;
        stall_data = 8'd0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                check("tx_hold_valid", 96'(bus.tx_data_valid), 96'd1);
                check("tx_hold_data", 96'(bus.tx_data), 96'(stall_data));
            end
            stall      = bus.tx_data_valid && !bus.tx_data_ready;
            stall_data = bus.tx_data;
            if (bus.tx_data_valid && bus.tx_data_ready) begin
                if (exp_tx_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: got %0h required none", bus.tx_data);
                end else begin
                    check("tx_byte", 96'(bus.tx_data), 96'(exp_tx_q.pop_front()));
                end
            end
            if (bus.write_valid) begin
                check("write_not_read", 96'(bus.read_valid), 96'd0);
                if (exp_bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL write_unexpected: got %0h required none", bus.write_address);
                end else begin
                    check("bus_write", 96'({1'b1, bus.write_address, bus.write_data}),
                          96'(exp_bus_q.pop_front()));
                end
            end
            if (bus.read_valid) begin
                if (exp_bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL read_unexpected: got %0h required none", bus.read_address);
                end else begin
                    check("bus_read", 96'({1'b0, bus.read_address, 32'd0}),
                          96'(exp_bus_q.pop_front()));
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int n;
        rst_n             = 1'b0;
        rd_resp           = 32'd0;
        bus.rx_data       = 8'd0;
        bus.rx_data_valid = 1'b0;
        bus.tx_data_ready = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk_in);
        check("rst_rx_ready", 96'(bus.rx_data_ready), 96'd1);
        check("rst_tx_valid", 96'(bus.tx_data_valid), 96'd0);
        check("rst_tx_data", 96'(bus.tx_data), 96'd0);
        check("rst_write_valid", 96'(bus.write_valid), 96'd0);
        check("rst_read_valid", 96'(bus.read_valid), 96'd0);
        check("rst_write_address", 96'(bus.write_address), 96'd0);
        check("rst_write_data", 96'(bus.write_data), 96'd0);
        check("rst_read_address", 96'(bus.read_address), 96'd0);
        sync();

        // Write frame with cycle-level timing
        send_write(32'h1000_0004, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk_in);
        check("wr_strobe_cycle", 96'(bus.write_valid), 96'd1);
        @(negedge clk_in);
        check("wr_strobe_one_cycle", 96'(bus.write_valid), 96'd0);
        check("wr_ack_valid", 96'(bus.tx_data_valid), 96'd1);
        check("wr_ack_data", 96'(bus.tx_data), 96'h4B);
        sync();
        drain();

        // Read frame with cycle-level timing
        send_read(32'h1000_0008, 32'h1234_5678);
        @(negedge clk_in);
        check("rd_strobe_cycle", 96'(bus.read_valid), 96'd1);
        @(negedge clk_in);
        check("rd_wait_strobe", 96'(bus.read_valid), 96'd0);
        check("rd_wait_tx_valid", 96'(bus.tx_data_valid), 96'd0);
        @(negedge clk_in);
        check("rd_first_valid", 96'(bus.tx_data_valid), 96'd1);
        check("rd_first_byte", 96'(bus.tx_data), 96'h12);
        sync();
        drain();

        // Unknown command then a normal write
        exp_tx_q.push_back(8'h3F);
        send_byte(8'h41);
        @(negedge clk_in);
        check("bad_cmd_state", 96'(state_dbg), 96'(S_RESP));
        check("bad_cmd_byte", 96'(bus.tx_data), 96'h3F);
        sync();
        send_write(32'h0000_0010, 32'hCAFE_BABE, 1'b1);
        drain();
        check("hold_write_address", 96'(bus.write_address), 96'h0000_0010);
        check("hold_write_data", 96'(bus.write_data), 96'hCAFE_BABE);

        // Timeout mid-address, then a read
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (15) sync();
        @(negedge clk_in);
        check("tmo_not_early", 96'(state_dbg), 96'(S_ADDR));
        sync();
        @(negedge clk_in);
        check("tmo_idle", 96'(state_dbg), 96'(S_IDLE));
        check("tmo_rx_ready", 96'(bus.rx_data_ready), 96'd1);
        sync();
        send_read(32'h1000_0000, 32'hA5A5_5A5A);
        drain();

        // Long tx backpressure during a read response
        bus.tx_data_ready = 1'b0;
        send_read(32'h1000_0008, 32'h1234_5678);
        n = 0;
        while (!bus.tx_data_valid && n < 20) begin
            sync();
            n++;
        end
        check("bp_resp_start", 96'(bus.tx_data_valid), 96'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            check("bp_valid", 96'(bus.tx_data_valid), 96'd1);
            check("bp_data", 96'(bus.tx_data), 96'h12);
            check("bp_rx_ready", 96'(bus.rx_data_ready), 96'd0);
        end
        sync();
        bus.tx_data_ready = 1'b1;
        drain();
        check("hold_read_address", 96'(bus.read_address), 96'h1000_0008);

        // Reset after the second data byte of a write
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk_in);
        check("mid_rst_state", 96'(state_dbg), 96'(S_IDLE));
        check("mid_rst_rx_ready", 96'(bus.rx_data_ready), 96'd1);
        check("mid_rst_write_address", 96'(bus.write_address), 96'd0);
        check("mid_rst_write_data", 96'(bus.write_data), 96'd0);
        check("mid_rst_read_address", 96'(bus.read_address), 96'd0);
        check("mid_rst_tx_valid", 96'(bus.tx_data_valid), 96'd0);
        sync();
        repeat (20) sync();
        send_write(32'h2000_000C, 32'h1122_3344, 1'b1);
        drain();
        check("final_write_address", 96'(bus.write_address), 96'h2000_000C);
        check("final_write_data", 96'(bus.write_data), 96'h1122_3344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
